// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared types and helpers for the ID/EX hazard and stall controller.
package hazard_stall_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        MEM_WAIT = 2'b01,
        FAULT    = 2'b10
    } state_e;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    function automatic logic reg_match(input logic [3:0] src,
                                       input logic [3:0] dest,
                                       input logic       wr_en);
        return wr_en & (src == dest);
    endfunction

    // MEM wins over WB because it holds the younger result for the same register.
    function automatic logic [1:0] fwd_select(input logic [3:0] src,
                                              input logic [3:0] mem_dest,
                                              input logic       mem_wb_en,
                                              input logic [3:0] wb_dest,
                                              input logic       wb_wb_en);
        logic [1:0] sel;
        if (reg_match(src, mem_dest, mem_wb_en)) begin
            sel = FWD_MEM;
        end else if (reg_match(src, wb_dest, wb_wb_en)) begin
            sel = FWD_WB;
        end else begin
            sel = FWD_REG;
        end
        return sel;
    endfunction

endpackage

// File: rtl/hazard_stall_ctrl_fwd_unit.sv
// Operand source-select compare for the EXE stage; used only when FORWARDING_EN is defined.
module hazard_stall_ctrl_fwd_unit
    import hazard_stall_ctrl_pkg::*;
(
    input  logic [3:0] exe_src1,
    input  logic [3:0] exe_src2,
    input  logic [3:0] mem_dest,
    input  logic       mem_wb_en,
    input  logic [3:0] wb_dest,
    input  logic       wb_wb_en,
    output logic [1:0] sel_a_o,
    output logic [1:0] sel_b_o
);

    // Per-operand source select.
    always_comb begin
        sel_a_o = fwd_select(exe_src1, mem_dest, mem_wb_en, wb_dest, wb_wb_en);
        sel_b_o = fwd_select(exe_src2, mem_dest, mem_wb_en, wb_dest, wb_wb_en);
    end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// ID/EX pipeline sequencing: memory-wait freeze, branch kill, RAW stall.
// Optional operand forwarding is enabled by defining FORWARDING_EN.
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int WAIT_LIMIT = 64,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       id_src1,
    input  logic             id_src1_valid,
    input  logic [3:0]       id_src2,
    input  logic             id_two_src,
    input  logic [3:0]       exe_dest,
    input  logic             exe_wb_en,
    input  logic             exe_mem_r_en,
    input  logic [3:0]       mem_dest,
    input  logic             mem_wb_en,
    input  logic [3:0]       wb_dest,
    input  logic             wb_wb_en,
    input  logic [3:0]       exe_src1,
    input  logic [3:0]       exe_src2,
    input  logic             exe_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             freeze_if,
    output logic             freeze_id,
    output logic             if_flush,
    output logic             id_flush,
    output logic             pipe_freeze,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [1:0]       fwd_sel_a,
    output logic [1:0]       fwd_sel_b
);

    localparam int WCNT_W = $clog2(WAIT_LIMIT + 1);

    state_e             state_q, state_d;
    logic [WCNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic               timeout_q, timeout_d;
    logic [CNT_W-1:0]   stall_q, stall_d;
    logic               mem_freeze_s;
    logic               hazard_s;
    logic [1:0]         sel_a_s, sel_b_s;

`ifdef FORWARDING_EN
    // Only a load in EXE cannot be bypassed; everything else is forwarded.
    assign hazard_s = exe_mem_r_en & exe_wb_en &
                      ((id_src1_valid & (id_src1 == exe_dest)) |
                       (id_two_src    & (id_src2 == exe_dest)));

    hazard_stall_ctrl_fwd_unit u_fwd_unit (
        .exe_src1  (exe_src1),
        .exe_src2  (exe_src2),
        .mem_dest  (mem_dest),
        .mem_wb_en (mem_wb_en),
        .wb_dest   (wb_dest),
        .wb_wb_en  (wb_wb_en),
        .sel_a_o   (sel_a_s),
        .sel_b_o   (sel_b_s)
    );
`else
    logic unused_s;

    assign hazard_s =
        (id_src1_valid & (reg_match(id_src1, exe_dest, exe_wb_en) |
                          reg_match(id_src1, mem_dest, mem_wb_en))) |
        (id_two_src    & (reg_match(id_src2, exe_dest, exe_wb_en) |
                          reg_match(id_src2, mem_dest, mem_wb_en)));
    assign sel_a_s  = FWD_REG;
    assign sel_b_s  = FWD_REG;
    assign unused_s = ^{wb_dest, wb_wb_en, exe_src1, exe_src2, exe_mem_r_en};
`endif

    assign mem_freeze_s = ((state_q == RUN)      & mem_req & ~mem_ready) |
                          ((state_q == MEM_WAIT) & ~mem_ready) |
                          (state_q == FAULT);

    // Prioritised freeze/flush decode; everything is held low while in reset.
    always_comb begin
        freeze_if   = 1'b0;
        freeze_id   = 1'b0;
        if_flush    = 1'b0;
        id_flush    = 1'b0;
        pipe_freeze = 1'b0;
        fwd_sel_a   = FWD_REG;
        fwd_sel_b   = FWD_REG;
        if (rst) begin
            freeze_if = 1'b0;
        end else begin
            fwd_sel_a = sel_a_s;
            fwd_sel_b = sel_b_s;
            if (mem_freeze_s) begin
                pipe_freeze = 1'b1;
                freeze_if   = 1'b1;
                freeze_id   = 1'b1;
            end else if (exe_branch_taken) begin
                if_flush = 1'b1;
                id_flush = 1'b1;
            end else if (hazard_s) begin
                freeze_if = 1'b1;
                freeze_id = 1'b1;
                id_flush  = 1'b1;
            end else begin
                freeze_if = 1'b0;
            end
        end
    end

    // Memory-wait FSM next state and timeout detection.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        timeout_d  = timeout_q;
        case (state_q)
            RUN: begin
                if (mem_req && !mem_ready) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = WCNT_W'(1);
                end else begin
                    state_d = RUN;
                end
            end
            MEM_WAIT: begin
                if (mem_ready) begin
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == WCNT_W'(WAIT_LIMIT)) begin
                    state_d   = FAULT;
                    timeout_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + WCNT_W'(1);
                end
            end
            FAULT: begin
                state_d = FAULT;
            end
            default: begin
                state_d    = RUN;
                wait_cnt_d = '0;
            end
        endcase
    end

    // Saturating count of front-end stall cycles.
    always_comb begin
        stall_d = stall_q;
        if (freeze_if && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + CNT_W'(1);
        end else begin
            stall_d = stall_q;
        end
    end

    // State and statistics registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
            stall_q    <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
            stall_q    <= stall_d;
        end
    end

    assign mem_timeout  = timeout_q;
    assign stall_cycles = stall_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed self-checking bench for hazard_stall_ctrl (WAIT_LIMIT=4, CNT_W=4).
module tb_hazard_stall_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] id_src1, id_src2, exe_dest, mem_dest, wb_dest, exe_src1, exe_src2;
    logic       id_src1_valid, id_two_src, exe_wb_en, exe_mem_r_en, mem_wb_en, wb_wb_en;
    logic       exe_branch_taken, mem_req, mem_ready;
    logic       freeze_if, freeze_id, if_flush, id_flush, pipe_freeze, mem_timeout;
    logic [3:0] stall_cycles;
    logic [1:0] fwd_sel_a, fwd_sel_b;

    int n_cmp = 0;
    int n_err = 0;

    hazard_stall_ctrl #(.WAIT_LIMIT(4), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .id_src1(id_src1), .id_src1_valid(id_src1_valid),
        .id_src2(id_src2), .id_two_src(id_two_src),
        .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
        .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
        .wb_dest(wb_dest), .wb_wb_en(wb_wb_en),
        .exe_src1(exe_src1), .exe_src2(exe_src2),
        .exe_branch_taken(exe_branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
        .freeze_if(freeze_if), .freeze_id(freeze_id), .if_flush(if_flush),
        .id_flush(id_flush), .pipe_freeze(pipe_freeze), .mem_timeout(mem_timeout),
        .stall_cycles(stall_cycles), .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_src1 = 4'd0; id_src2 = 4'd0; exe_dest = 4'd0; mem_dest = 4'd0;
        wb_dest = 4'd0; exe_src1 = 4'd0; exe_src2 = 4'd0;
        id_src1_valid = 1'b0; id_two_src = 1'b0; exe_wb_en = 1'b0;
        exe_mem_r_en = 1'b0; mem_wb_en = 1'b0; wb_wb_en = 1'b0;
        exe_branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        logic [5:0] outs;
        rst = 1'b1;
        clear_inputs();
        id_src1 = 4'd3; id_src1_valid = 1'b1; exe_dest = 4'd3; exe_wb_en = 1'b1;
        exe_mem_r_en = 1'b1; exe_branch_taken = 1'b1; mem_req = 1'b1;
        #1;
        outs = {freeze_if, freeze_id, if_flush, id_flush, pipe_freeze, |{fwd_sel_a, fwd_sel_b}};
        n_cmp++;
        if (outs !== 6'b000000) begin
            n_err++;
            $display("FAIL reset_comb_outputs: got %b expected 000000", outs);
        end
        tick();
        tick();
        n_cmp++;
        if ({mem_timeout, stall_cycles} !== 5'b0_0000) begin
            n_err++;
            $display("FAIL reset_regs: timeout=%b stall=%h expected 0/0", mem_timeout, stall_cycles);
        end
        rst = 1'b0;
        clear_inputs();
        #1;
        n_cmp++;
        if (pipe_freeze !== 1'b0) begin
            n_err++;
            $display("FAIL reset_run_state: pipe_freeze=%b expected 0", pipe_freeze);
        end
    endtask

    task automatic test_branch_with_hazard();
        do_reset();
        id_src1 = 4'd3; id_src1_valid = 1'b1; exe_dest = 4'd3; exe_wb_en = 1'b1;
        exe_mem_r_en = 1'b1;
        exe_branch_taken = 1'b1;
        #1;
        n_cmp++;
        if ({if_flush, id_flush, freeze_if, freeze_id, pipe_freeze} !== 5'b11000) begin
            n_err++;
            $display("FAIL branch_kill: {ifl,idl,fif,fid,pf}=%b expected 11000",
                     {if_flush, id_flush, freeze_if, freeze_id, pipe_freeze});
        end
        tick();
        n_cmp++;
        if (stall_cycles !== 4'd0) begin
            n_err++;
            $display("FAIL branch_no_stall_count: stall=%h expected 0", stall_cycles);
        end
        clear_inputs();
    endtask

    task automatic test_mem_wait();
        int frz = 0;
        do_reset();
        mem_req = 1'b1;
        exe_branch_taken = 1'b1;
        for (int c = 0; c < 4; c++) begin
            mem_ready = (c == 3);
            #1;
            if (pipe_freeze === 1'b1) frz++;
            if (c == 0) begin
                n_cmp++;
                if ({pipe_freeze, freeze_if, freeze_id, if_flush, id_flush} !== 5'b11100) begin
                    n_err++;
                    $display("FAIL mem_freeze_priority: {pf,fif,fid,ifl,idl}=%b expected 11100",
                             {pipe_freeze, freeze_if, freeze_id, if_flush, id_flush});
                end
            end
            if (c == 3) begin
                n_cmp++;
                if (pipe_freeze !== 1'b0) begin
                    n_err++;
                    $display("FAIL mem_ready_release: pipe_freeze=%b expected 0", pipe_freeze);
                end
            end
            tick();
        end
        n_cmp++;
        if (frz != 3) begin
            n_err++;
            $display("FAIL mem_wait_len: frozen %0d cycles expected 3", frz);
        end
        mem_req = 1'b0; mem_ready = 1'b0; exe_branch_taken = 1'b0;
        #1;
        n_cmp++;
        if (pipe_freeze !== 1'b0) begin
            n_err++;
            $display("FAIL mem_back_to_run: pipe_freeze=%b expected 0", pipe_freeze);
        end
        // Ready in the first cycle of an access must not freeze.
        mem_req = 1'b1; mem_ready = 1'b1;
        #1;
        n_cmp++;
        if (pipe_freeze !== 1'b0) begin
            n_err++;
            $display("FAIL mem_ready_first: pipe_freeze=%b expected 0", pipe_freeze);
        end
        clear_inputs();
    endtask

    task automatic test_timeout();
        do_reset();
        mem_req = 1'b1; mem_ready = 1'b0;
        // Edge 1 enters the wait (count 1); four more not-ready edges are needed.
        for (int e = 0; e < 4; e++) tick();
        n_cmp++;
        if (mem_timeout !== 1'b0) begin
            n_err++;
            $display("FAIL timeout_early: mem_timeout=%b expected 0", mem_timeout);
        end
        tick();
        n_cmp++;
        if (mem_timeout !== 1'b1) begin
            n_err++;
            $display("FAIL timeout_set: mem_timeout=%b expected 1", mem_timeout);
        end
        mem_ready = 1'b1; mem_req = 1'b0;
        tick();
        n_cmp++;
        if ({pipe_freeze, mem_timeout} !== 2'b11) begin
            n_err++;
            $display("FAIL fault_sticky: {pf,timeout}=%b expected 11", {pipe_freeze, mem_timeout});
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({pipe_freeze, mem_timeout, stall_cycles} !== 6'b0) begin
            n_err++;
            $display("FAIL fault_reset: {pf,timeout,stall}=%b expected 000000",
                     {pipe_freeze, mem_timeout, stall_cycles});
        end
        clear_inputs();
    endtask

`ifndef FORWARDING_EN
    task automatic test_raw();
        do_reset();
        id_src1 = 4'd3; id_src1_valid = 1'b1; exe_dest = 4'd3; exe_wb_en = 1'b1;
        #1;
        n_cmp++;
        if ({freeze_if, freeze_id, id_flush, if_flush, pipe_freeze} !== 5'b11100) begin
            n_err++;
            $display("FAIL raw_exe_src1: {fif,fid,idl,ifl,pf}=%b expected 11100",
                     {freeze_if, freeze_id, id_flush, if_flush, pipe_freeze});
        end
        tick();
        n_cmp++;
        if (stall_cycles !== 4'd1) begin
            n_err++;
            $display("FAIL raw_stall_count: stall=%h expected 1", stall_cycles);
        end
        clear_inputs();
        id_src2 = 4'd9; mem_dest = 4'd9; mem_wb_en = 1'b1;
        #1;
        n_cmp++;
        if (freeze_if !== 1'b0) begin
            n_err++;
            $display("FAIL raw_src2_unused: freeze_if=%b expected 0", freeze_if);
        end
        id_two_src = 1'b1;
        #1;
        n_cmp++;
        if ({freeze_if, id_flush} !== 2'b11) begin
            n_err++;
            $display("FAIL raw_mem_src2: {fif,idl}=%b expected 11", {freeze_if, id_flush});
        end
        mem_wb_en = 1'b0;
        #1;
        n_cmp++;
        if (freeze_if !== 1'b0) begin
            n_err++;
            $display("FAIL raw_no_wb: freeze_if=%b expected 0", freeze_if);
        end
        clear_inputs();
        id_src1 = 4'd7; exe_dest = 4'd7; exe_wb_en = 1'b1;
        #1;
        n_cmp++;
        if (freeze_if !== 1'b0) begin
            n_err++;
            $display("FAIL raw_src1_invalid: freeze_if=%b expected 0", freeze_if);
        end
        clear_inputs();
    endtask
`else
    task automatic test_forwarding();
        do_reset();
        exe_src1 = 4'd5; mem_dest = 4'd5; mem_wb_en = 1'b1; wb_dest = 4'd5; wb_wb_en = 1'b1;
        exe_src2 = 4'd5;
        #1;
        n_cmp++;
        if ({fwd_sel_a, fwd_sel_b} !== 4'b0101) begin
            n_err++;
            $display("FAIL fwd_mem_priority: a=%b b=%b expected 01/01", fwd_sel_a, fwd_sel_b);
        end
        exe_src2 = 4'd6; wb_dest = 4'd6;
        #1;
        n_cmp++;
        if ({fwd_sel_a, fwd_sel_b} !== 4'b0110) begin
            n_err++;
            $display("FAIL fwd_wb: a=%b b=%b expected 01/10", fwd_sel_a, fwd_sel_b);
        end
        clear_inputs();
        id_src1 = 4'd3; id_src1_valid = 1'b1; exe_dest = 4'd3; exe_wb_en = 1'b1;
        #1;
        n_cmp++;
        if (freeze_if !== 1'b0) begin
            n_err++;
            $display("FAIL fwd_nonload_nostall: freeze_if=%b expected 0", freeze_if);
        end
        exe_mem_r_en = 1'b1;
        #1;
        n_cmp++;
        if ({freeze_if, freeze_id, id_flush} !== 3'b111) begin
            n_err++;
            $display("FAIL fwd_load_use: {fif,fid,idl}=%b expected 111",
                     {freeze_if, freeze_id, id_flush});
        end
        clear_inputs();
    endtask
`endif

    task automatic test_saturation();
        do_reset();
        id_src1 = 4'd3; id_src1_valid = 1'b1; exe_dest = 4'd3; exe_wb_en = 1'b1;
        exe_mem_r_en = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        n_cmp++;
        if (stall_cycles !== 4'd5) begin
            n_err++;
            $display("FAIL stall_count_5: stall=%h expected 5", stall_cycles);
        end
        for (int i = 0; i < 15; i++) tick();
        n_cmp++;
        if (stall_cycles !== 4'hF) begin
            n_err++;
            $display("FAIL stall_saturate: stall=%h expected F", stall_cycles);
        end
        clear_inputs();
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
`ifndef FORWARDING_EN
        test_raw();
`else
        test_forwarding();
`endif
        test_branch_with_hazard();
        test_mem_wait();
        test_timeout();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
